// File: rtl/vga_fb_reader.sv
// vga_fb_reader: Wishbone burst read master that keeps a show-ahead word FIFO
// topped up from a DDR2 framebuffer and unpacks two xRGB pixels per 64-bit
// word into a 24-bit pixel stream.
module vga_fb_reader #(
    parameter logic [31:0] BASE_ADDR   = 32'h3c000,
    parameter logic [31:0] FRAME_WORDS = 32'h3a980,
    parameter int          BURST_LEN   = 4,
    parameter int          FIFO_AW     = 4
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        enable,
    input  logic        frame_start,
    output logic [31:0] wbm_adr_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [7:0]  wbm_sel_o,
    output logic [63:0] wbm_dat_o,
    input  logic [63:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        pix_rd,
    output logic        pix_valid,
    output logic [23:0] pix_data,
    output logic        frame_done,
    output logic        underflow,
    output logic        bus_err
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int BW    = $clog2(BURST_LEN + 1);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    // Registered state
    state_t               r_state;
    logic [31:0]          r_adr;
    logic [2:0]           r_cti;
    logic                 r_cyc;
    logic [BW-1:0]        r_beats_left;
    logic [31:0]          r_word_cnt;
    logic [FIFO_AW-1:0]   r_wr_ptr;
    logic [FIFO_AW-1:0]   r_rd_ptr;
    logic [FIFO_AW:0]     r_count;
    logic                 r_half;
    logic                 r_restart_pend;
    logic                 r_underflow;
    logic                 r_bus_err;

    // Only the two 24-bit pixel fields of each word are kept
    logic [47:0]          r_mem [DEPTH];

    // Next-state values
    state_t               w_state_next;
    logic [31:0]          w_adr_next;
    logic [2:0]           w_cti_next;
    logic                 w_cyc_next;
    logic [BW-1:0]        w_beats_left_next;
    logic [31:0]          w_word_cnt_next;
    logic [FIFO_AW-1:0]   w_wr_ptr_next;
    logic [FIFO_AW-1:0]   w_rd_ptr_next;
    logic [FIFO_AW:0]     w_count_next;
    logic                 w_half_next;
    logic                 w_restart_pend_next;
    logic                 w_underflow_next;
    logic                 w_bus_err_next;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_flush;
    logic                 w_pix_valid;
    logic [31:0]          w_remain;
    logic [BW-1:0]        w_beats;
    logic                 w_space_ok;
    logic [47:0]          w_head;
    logic                 w_unused;

    // Padding bytes of each xRGB pixel are never displayed
    assign w_unused = ^{wbm_dat_i[63:56], wbm_dat_i[31:24]};

    assign w_pix_valid = (r_count != '0) && !r_restart_pend;
    assign w_remain    = FRAME_WORDS - r_word_cnt;
    assign w_beats     = (w_remain < 32'(BURST_LEN)) ? w_remain[BW-1:0] : BW'(BURST_LEN);
    // Space for a whole burst is reserved up front so pushes never stall
    assign w_space_ok  = (32'(r_count) + 32'(BURST_LEN)) <= 32'(DEPTH);
    assign w_head      = r_mem[r_rd_ptr];

    // Next-state logic: bus FSM, pixel unpack, FIFO bookkeeping and frame restart
    always_comb begin
        w_state_next        = r_state;
        w_adr_next          = r_adr;
        w_cti_next          = r_cti;
        w_cyc_next          = r_cyc;
        w_beats_left_next   = r_beats_left;
        w_word_cnt_next     = r_word_cnt;
        w_half_next         = r_half;
        w_restart_pend_next = r_restart_pend;
        w_underflow_next    = r_underflow;
        w_bus_err_next      = r_bus_err;
        w_push              = 1'b0;
        w_pop               = 1'b0;
        w_flush             = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_restart_pend || frame_start) begin
                    w_flush = 1'b1;
                end else if (enable && (r_word_cnt < FRAME_WORDS) && w_space_ok) begin
                    w_state_next      = S_BURST;
                    w_cyc_next        = 1'b1;
                    w_adr_next        = BASE_ADDR + (r_word_cnt << 3);
                    w_cti_next        = (w_beats == BW'(1)) ? 3'b111 : 3'b010;
                    w_beats_left_next = w_beats;
                end
            end
            S_BURST: begin
                if (frame_start) begin
                    w_restart_pend_next = 1'b1;
                end
                if (wbm_err_i) begin
                    // Errored beat is dropped; the same word is refetched later
                    w_bus_err_next = 1'b1;
                    w_cyc_next     = 1'b0;
                    w_cti_next     = 3'b000;
                    w_state_next   = S_IDLE;
                end else if (wbm_ack_i) begin
                    w_push            = 1'b1;
                    w_word_cnt_next   = r_word_cnt + 32'd1;
                    w_adr_next        = r_adr + 32'd8;
                    w_beats_left_next = r_beats_left - BW'(1);
                    if (r_beats_left == BW'(1)) begin
                        w_cyc_next   = 1'b0;
                        w_cti_next   = 3'b000;
                        w_state_next = S_IDLE;
                    end else if (r_beats_left == BW'(2)) begin
                        w_cti_next = 3'b111;
                    end else begin
                        w_cti_next = 3'b010;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cyc_next   = 1'b0;
            end
        endcase

        if (pix_rd) begin
            if (w_pix_valid) begin
                w_half_next = ~r_half;
                w_pop       = r_half;
            end else begin
                w_underflow_next = 1'b1;
            end
        end

        w_wr_ptr_next = r_wr_ptr + FIFO_AW'(w_push);
        w_rd_ptr_next = r_rd_ptr + FIFO_AW'(w_pop);
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase

        // Frame restart overrides everything else on the pixel side
        if (w_flush) begin
            w_word_cnt_next     = '0;
            w_wr_ptr_next       = '0;
            w_rd_ptr_next       = '0;
            w_count_next        = '0;
            w_half_next         = 1'b0;
            w_underflow_next    = 1'b0;
            w_bus_err_next      = 1'b0;
            w_restart_pend_next = 1'b0;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_state        <= S_IDLE;
            r_adr          <= BASE_ADDR;
            r_cti          <= 3'b000;
            r_cyc          <= 1'b0;
            r_beats_left   <= '0;
            r_word_cnt     <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_half         <= 1'b0;
            r_restart_pend <= 1'b0;
            r_underflow    <= 1'b0;
            r_bus_err      <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_adr          <= w_adr_next;
            r_cti          <= w_cti_next;
            r_cyc          <= w_cyc_next;
            r_beats_left   <= w_beats_left_next;
            r_word_cnt     <= w_word_cnt_next;
            r_wr_ptr       <= w_wr_ptr_next;
            r_rd_ptr       <= w_rd_ptr_next;
            r_count        <= w_count_next;
            r_half         <= w_half_next;
            r_restart_pend <= w_restart_pend_next;
            r_underflow    <= w_underflow_next;
            r_bus_err      <= w_bus_err_next;
        end
    end

    // FIFO storage write port
    always_ff @(posedge wb_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {wbm_dat_i[55:32], wbm_dat_i[23:0]};
        end
    end

    assign wbm_adr_o  = r_adr;
    assign wbm_cti_o  = r_cti;
    assign wbm_bte_o  = 2'b00;
    assign wbm_cyc_o  = r_cyc;
    assign wbm_stb_o  = r_cyc;
    assign wbm_we_o   = 1'b0;
    assign wbm_sel_o  = 8'hff;
    assign wbm_dat_o  = 64'd0;

    assign pix_valid  = w_pix_valid;
    assign pix_data   = r_half ? w_head[47:24] : w_head[23:0];
    assign frame_done = (r_word_cnt == FRAME_WORDS);
    assign underflow  = r_underflow;
    assign bus_err    = r_bus_err;

endmodule

// File: tb/tb_vga_fb_reader.sv
// Directed bench for vga_fb_reader: three instances with different frame
// sizes, each driven by a simple always-ack Wishbone slave stepped on negedge.
module tb_vga_fb_reader;

    localparam int          N    = 3;
    localparam logic [31:0] BASE = 32'h3c000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]        rst, en, fs, ack, err, prd;
    logic [N-1:0][63:0]  dat_i;
    logic [N-1:0][31:0]  adr;
    logic [N-1:0][2:0]   cti;
    logic [N-1:0][1:0]   bte;
    logic [N-1:0]        cyc, stb, we;
    logic [N-1:0][7:0]   sel;
    logic [N-1:0][63:0]  dat_o;
    logic [N-1:0]        pv, fd, uf, be;
    logic [N-1:0][23:0]  pd;

    // dut 0: 8 words, dut 1: 64 words, dut 2: 6 words
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            localparam logic [31:0] FW = (gi == 0) ? 32'd8 : (gi == 1) ? 32'd64 : 32'd6;
            vga_fb_reader #(
                .BASE_ADDR(BASE), .FRAME_WORDS(FW), .BURST_LEN(4), .FIFO_AW(4)
            ) u_dut (
                .wb_clk(clk), .wb_rst(rst[gi]), .enable(en[gi]), .frame_start(fs[gi]),
                .wbm_adr_o(adr[gi]), .wbm_cti_o(cti[gi]), .wbm_bte_o(bte[gi]),
                .wbm_cyc_o(cyc[gi]), .wbm_stb_o(stb[gi]), .wbm_we_o(we[gi]),
                .wbm_sel_o(sel[gi]), .wbm_dat_o(dat_o[gi]), .wbm_dat_i(dat_i[gi]),
                .wbm_ack_i(ack[gi]), .wbm_err_i(err[gi]), .pix_rd(prd[gi]),
                .pix_valid(pv[gi]), .pix_data(pd[gi]), .frame_done(fd[gi]),
                .underflow(uf[gi]), .bus_err(be[gi])
            );
        end
    endgenerate

    int n_cmp = 0;
    int n_bad = 0;
    int beat_idx = 0;
    int err_beat = -1;
    logic [31:0] log_adr [$];
    logic [2:0]  log_cti [$];

    // Slave memory image: word at BASE is the pixel-order pattern
    function automatic logic [63:0] slave_word(input logic [31:0] a);
        logic [23:0] lo;
        lo = a[23:0];
        if (a == BASE) return 64'h00ff0000_0000ff00;
        return {8'hee, lo + 24'h1, 8'hee, lo};
    endfunction

    function automatic logic [23:0] pix_exp(input logic [31:0] a, input bit h);
        logic [23:0] lo;
        lo = a[23:0];
        if (a == BASE) return h ? 24'hff0000 : 24'h00ff00;
        return h ? lo + 24'h1 : lo;
    endfunction

    // Advance to the next negedge and answer the bus of instance i
    task automatic step(input int i);
        @(negedge clk);
        if (cyc[i]) begin
            ack[i]   = 1'b1;
            dat_i[i] = slave_word(adr[i]);
            if (beat_idx == err_beat) begin
                err[i] = 1'b1;
            end else begin
                err[i] = 1'b0;
                log_adr.push_back(adr[i]);
                log_cti.push_back(cti[i]);
            end
            beat_idx++;
        end else begin
            ack[i]   = 1'b0;
            err[i]   = 1'b0;
            beat_idx = 0;
        end
    endtask

    task automatic test_reset();
        rst = '1; en = '0; fs = '0; prd = '0; ack = '0; err = '0; dat_i = '0;
        repeat (3) step(0);
        n_cmp++; if (cyc[0] !== 1'b0)        begin n_bad++; $display("FAIL reset_cyc got %b want 0", cyc[0]); end
        n_cmp++; if (stb[0] !== 1'b0)        begin n_bad++; $display("FAIL reset_stb got %b want 0", stb[0]); end
        n_cmp++; if (we[0] !== 1'b0)         begin n_bad++; $display("FAIL reset_we got %b want 0", we[0]); end
        n_cmp++; if (cti[0] !== 3'b000)      begin n_bad++; $display("FAIL reset_cti got %b want 000", cti[0]); end
        n_cmp++; if (bte[0] !== 2'b00)       begin n_bad++; $display("FAIL reset_bte got %b want 00", bte[0]); end
        n_cmp++; if (sel[0] !== 8'hff)       begin n_bad++; $display("FAIL reset_sel got %h want ff", sel[0]); end
        n_cmp++; if (dat_o[0] !== 64'd0)     begin n_bad++; $display("FAIL reset_dat_o got %h want 0", dat_o[0]); end
        n_cmp++; if (adr[0] !== 32'h3c000)   begin n_bad++; $display("FAIL reset_adr got %h want 3c000", adr[0]); end
        n_cmp++; if (pv[0] !== 1'b0)         begin n_bad++; $display("FAIL reset_pix_valid got %b want 0", pv[0]); end
        n_cmp++; if (fd[0] !== 1'b0)         begin n_bad++; $display("FAIL reset_frame_done got %b want 0", fd[0]); end
        n_cmp++; if (uf[0] !== 1'b0)         begin n_bad++; $display("FAIL reset_underflow got %b want 0", uf[0]); end
        n_cmp++; if (be[0] !== 1'b0)         begin n_bad++; $display("FAIL reset_bus_err got %b want 0", be[0]); end
        rst = '0;
        $display("test_reset: reset values checked");
    endtask

    task automatic test_two_bursts();
        log_adr.delete(); log_cti.delete();
        en[0] = 1'b1;
        repeat (20) step(0);
        n_cmp++; if (log_adr.size() !== 8) begin n_bad++; $display("FAIL two_bursts_beats got %0d want 8", log_adr.size()); end
        for (int k = 0; k < 8 && k < log_adr.size(); k++) begin
            n_cmp++; if (log_adr[k] !== BASE + 32'(8 * k)) begin n_bad++; $display("FAIL two_bursts_adr[%0d] got %h want %h", k, log_adr[k], BASE + 32'(8 * k)); end
            n_cmp++; if (log_cti[k] !== ((k % 4 == 3) ? 3'b111 : 3'b010)) begin n_bad++; $display("FAIL two_bursts_cti[%0d] got %b", k, log_cti[k]); end
        end
        n_cmp++; if (fd[0] !== 1'b1)  begin n_bad++; $display("FAIL two_bursts_frame_done got %b want 1", fd[0]); end
        n_cmp++; if (cyc[0] !== 1'b0) begin n_bad++; $display("FAIL two_bursts_cyc_idle got %b want 0", cyc[0]); end
        // Drain all 16 pixels: exactly 8 words are held
        for (int k = 0; k < 16; k++) begin
            n_cmp++; if (pv[0] !== 1'b1) begin n_bad++; $display("FAIL drain_valid[%0d] got %b want 1", k, pv[0]); end
            n_cmp++; if (pd[0] !== pix_exp(BASE + 32'(8 * (k / 2)), k[0])) begin n_bad++; $display("FAIL drain_pix[%0d] got %h want %h", k, pd[0], pix_exp(BASE + 32'(8 * (k / 2)), k[0])); end
            prd[0] = 1'b1;
            step(0);
        end
        prd[0] = 1'b0;
        n_cmp++; if (pv[0] !== 1'b0) begin n_bad++; $display("FAIL drain_empty got %b want 0", pv[0]); end
        $display("test_two_bursts: %0d beats, 16 pixels drained", log_adr.size());
    endtask

    task automatic test_underflow();
        prd[0] = 1'b1;
        step(0);
        prd[0] = 1'b0;
        n_cmp++; if (uf[0] !== 1'b1) begin n_bad++; $display("FAIL underflow_set got %b want 1", uf[0]); end
        repeat (3) step(0);
        n_cmp++; if (uf[0] !== 1'b1) begin n_bad++; $display("FAIL underflow_sticky got %b want 1", uf[0]); end
        en[0] = 1'b0;
        fs[0] = 1'b1;
        step(0);
        fs[0] = 1'b0;
        n_cmp++; if (uf[0] !== 1'b0) begin n_bad++; $display("FAIL underflow_clear got %b want 0", uf[0]); end
        n_cmp++; if (fd[0] !== 1'b0) begin n_bad++; $display("FAIL restart_frame_done got %b want 0", fd[0]); end
        $display("test_underflow: sticky flag and frame_start clear checked");
    endtask

    task automatic test_err();
        bit got;
        log_adr.delete(); log_cti.delete();
        err_beat = 1;
        en[0] = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            step(0);
            if (be[0]) got = 1'b1;
        end
        en[0] = 1'b0;
        err_beat = -1;
        n_cmp++; if (!got) begin n_bad++; $display("FAIL err_timeout bus_err got 0 want 1"); end
        n_cmp++; if (cyc[0] !== 1'b0) begin n_bad++; $display("FAIL err_cyc_drop got %b want 0", cyc[0]); end
        n_cmp++; if (log_adr.size() !== 1) begin n_bad++; $display("FAIL err_beats got %0d want 1", log_adr.size()); end
        // Exactly one word (two pixels) must have been pushed
        n_cmp++; if (pv[0] !== 1'b1 || pd[0] !== 24'h00ff00) begin n_bad++; $display("FAIL err_word_lo got v=%b %h want v=1 00ff00", pv[0], pd[0]); end
        prd[0] = 1'b1;
        step(0);
        n_cmp++; if (pv[0] !== 1'b1 || pd[0] !== 24'hff0000) begin n_bad++; $display("FAIL err_word_hi got v=%b %h want v=1 ff0000", pv[0], pd[0]); end
        step(0);
        prd[0] = 1'b0;
        n_cmp++; if (pv[0] !== 1'b0) begin n_bad++; $display("FAIL err_one_word got %b want 0", pv[0]); end
        log_adr.delete(); log_cti.delete();
        en[0] = 1'b1;
        repeat (20) step(0);
        n_cmp++; if (log_adr.size() !== 7) begin n_bad++; $display("FAIL retry_beats got %0d want 7", log_adr.size()); end
        if (log_adr.size() == 7) begin
            n_cmp++; if (log_adr[0] !== 32'h3c008) begin n_bad++; $display("FAIL retry_adr0 got %h want 3c008", log_adr[0]); end
            n_cmp++; if (log_cti[3] !== 3'b111)    begin n_bad++; $display("FAIL retry_cti3 got %b want 111", log_cti[3]); end
            n_cmp++; if (log_adr[4] !== 32'h3c028) begin n_bad++; $display("FAIL retry_adr4 got %h want 3c028", log_adr[4]); end
            n_cmp++; if (log_adr[6] !== 32'h3c038 || log_cti[6] !== 3'b111) begin n_bad++; $display("FAIL retry_last got %h/%b want 3c038/111", log_adr[6], log_cti[6]); end
        end
        $display("test_err: error beat dropped, retry from 3c008");
    endtask

    task automatic test_restart();
        bit got;
        en[0] = 1'b0;
        fs[0] = 1'b1;
        step(0);
        fs[0] = 1'b0;
        log_adr.delete(); log_cti.delete();
        en[0] = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin step(0); if (cyc[0]) got = 1'b1; end
        n_cmp++; if (!got) begin n_bad++; $display("FAIL restart_start_timeout cyc got 0 want 1"); end
        fs[0] = 1'b1;
        step(0);
        fs[0] = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin step(0); if (!cyc[0]) got = 1'b1; end
        n_cmp++; if (!got) begin n_bad++; $display("FAIL restart_end_timeout cyc got 1 want 0"); end
        n_cmp++; if (log_adr.size() !== 4) begin n_bad++; $display("FAIL restart_burst_beats got %0d want 4", log_adr.size()); end
        got = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin step(0); if (cyc[0]) got = 1'b1; end
        n_cmp++; if (!got) begin n_bad++; $display("FAIL restart_next_timeout cyc got 0 want 1"); end
        n_cmp++; if (pv[0] !== 1'b0)   begin n_bad++; $display("FAIL restart_flushed got %b want 0", pv[0]); end
        n_cmp++; if (adr[0] !== BASE)  begin n_bad++; $display("FAIL restart_adr got %h want 3c000", adr[0]); end
        n_cmp++; if (fd[0] !== 1'b0)   begin n_bad++; $display("FAIL restart_word_cnt frame_done got %b want 0", fd[0]); end
        en[0] = 1'b0;
        $display("test_restart: burst completed, frame restarted at 3c000");
    endtask

    task automatic test_fifo_full();
        log_adr.delete(); log_cti.delete();
        en[1] = 1'b1;
        repeat (60) step(1);
        n_cmp++; if (log_adr.size() !== 16) begin n_bad++; $display("FAIL full_beats got %0d want 16", log_adr.size()); end
        n_cmp++; if (cyc[1] !== 1'b0) begin n_bad++; $display("FAIL full_cyc got %b want 0", cyc[1]); end
        prd[1] = 1'b1;
        repeat (8) step(1);
        prd[1] = 1'b0;
        repeat (20) step(1);
        n_cmp++; if (log_adr.size() !== 20) begin n_bad++; $display("FAIL refill_beats got %0d want 20", log_adr.size()); end
        if (log_adr.size() == 20) begin
            n_cmp++; if (log_adr[16] !== 32'h3c080) begin n_bad++; $display("FAIL refill_adr got %h want 3c080", log_adr[16]); end
            n_cmp++; if (log_cti[19] !== 3'b111)    begin n_bad++; $display("FAIL refill_cti got %b want 111", log_cti[19]); end
        end
        $display("test_fifo_full: %0d beats total", log_adr.size());
    endtask

    task automatic test_short_burst();
        log_adr.delete(); log_cti.delete();
        en[2] = 1'b1;
        repeat (20) step(2);
        n_cmp++; if (log_adr.size() !== 6) begin n_bad++; $display("FAIL short_beats got %0d want 6", log_adr.size()); end
        if (log_adr.size() == 6) begin
            n_cmp++; if (log_cti[3] !== 3'b111) begin n_bad++; $display("FAIL short_cti3 got %b want 111", log_cti[3]); end
            n_cmp++; if (log_adr[4] !== 32'h3c020 || log_cti[4] !== 3'b010) begin n_bad++; $display("FAIL short_beat4 got %h/%b want 3c020/010", log_adr[4], log_cti[4]); end
            n_cmp++; if (log_adr[5] !== 32'h3c028 || log_cti[5] !== 3'b111) begin n_bad++; $display("FAIL short_beat5 got %h/%b want 3c028/111", log_adr[5], log_cti[5]); end
        end
        n_cmp++; if (fd[2] !== 1'b1) begin n_bad++; $display("FAIL short_frame_done got %b want 1", fd[2]); end
        $display("test_short_burst: %0d beats", log_adr.size());
    endtask

    task automatic test_pixel_order();
        n_cmp++; if (pv[2] !== 1'b1 || pd[2] !== 24'h00ff00) begin n_bad++; $display("FAIL order_pix0 got v=%b %h want v=1 00ff00", pv[2], pd[2]); end
        prd[2] = 1'b1;
        step(2);
        n_cmp++; if (pd[2] !== 24'hff0000) begin n_bad++; $display("FAIL order_pix1 got %h want ff0000", pd[2]); end
        step(2);
        prd[2] = 1'b0;
        n_cmp++; if (pd[2] !== 24'h03c008) begin n_bad++; $display("FAIL order_pix2 got %h want 03c008", pd[2]); end
        $display("test_pixel_order: low pixel then high pixel");
    endtask

    initial begin
        test_reset();
        test_two_bursts();
        test_underflow();
        test_err();
        test_restart();
        test_fifo_full();
        test_short_burst();
        test_pixel_order();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
